// File: rtl/round_scorer_pkg.sv
// Shared definitions for the round scorer: FSM state encoding, the BCD digit
// limit and a helper that turns a small integer into two packed BCD digits.
package round_scorer_pkg;

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_WAIT_FIRST  = 3'd1,
        S_WAIT_SECOND = 3'd2,
        S_EVAL        = 3'd3,
        S_DONE        = 3'd4
    } state_e;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Two-digit BCD image of value, clamped to 99 like the display counters.
    function automatic logic [7:0] to_bcd(input int unsigned value);
        int unsigned v;
        v = (value > 99) ? 99 : value;
        return {4'(v / 10), 4'(v % 10)};
    endfunction

endpackage

// File: rtl/round_scorer_bcd_counter2.sv
// Two-digit BCD up-counter with synchronous clear. The ones digit wraps 9->0
// and carries into tens; once the count reaches 99 further increments are held.
module bcd_counter2
    import round_scorer_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc,
    output logic [7:0] bcd
);

    logic [3:0] ones_q, ones_d;
    logic [3:0] tens_q, tens_d;

    // Next digit values: clear wins over increment, increment saturates at 99.
    always_comb begin
        // NOTE: defaulting every output first keeps this block free of latches.
        ones_d = ones_q;
        tens_d = tens_q;
        if (clr) begin
            ones_d = '0;
            tens_d = '0;
        end else if (inc) begin
            if (ones_q != BCD_MAX) begin
                ones_d = ones_q + 4'd1;
            end else if (tens_q != BCD_MAX) begin
                ones_d = '0;
                tens_d = tens_q + 4'd1;
            end
        end
    end

    // Digit registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            ones_q <= '0;
            tens_q <= '0;
        end else begin
            ones_q <= ones_d;
            tens_q <= tens_d;
        end
    end

    assign bcd = {tens_q, ones_q};

endmodule

// File: rtl/round_scorer.sv
// Round scorer: after login, groups P1/P2 load strobes into rounds, scores each
// round as a hit or a miss (mismatch or second-player timeout) and presents BCD
// hit/miss/round counts plus a game-over level. Logout clears everything.
module round_scorer
    import round_scorer_pkg::*;
#(
    parameter int MAX_ROUNDS     = 9,
    parameter int TIMEOUT_CYCLES = 50_000_000,
    parameter int TW             = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       logged_in,
    input  logic       load_p1,
    input  logic       load_p2,
    input  logic       is_match,
    output logic [7:0] hits_bcd,
    output logic [7:0] misses_bcd,
    output logic [7:0] round_bcd,
    output logic       round_done,
    output logic       timeout_evt,
    output logic       game_over
);

    // Round count just before the final round is scored, in BCD, so the
    // game-end decision can be taken from the current counter value.
    localparam logic [7:0]    LAST_ROUND_BCD = to_bcd(MAX_ROUNDS - 1);
    localparam logic [TW-1:0] TIMER_LAST     = TW'(TIMEOUT_CYCLES - 1);

    state_e        state_q;
    logic          first_p1_q;
    logic [TW-1:0] timer_q;
    logic          round_done_q;
    logic          timeout_evt_q;
    logic          game_over_q;

    logic clr;
    logic second_strobe;
    logic timer_expired;
    logic eval_score;
    logic timeout_score;
    logic score;
    logic hit_inc;
    logic miss_inc;
    logic last_round;

    // Logout clears the counters; every scoring path is gated by login so a
    // logout in the same cycle always wins.
    assign clr           = ~logged_in;
    assign second_strobe = first_p1_q ? load_p2 : load_p1;
    assign timer_expired = (timer_q == TIMER_LAST);
    assign eval_score    = logged_in && (state_q == S_EVAL);
    assign timeout_score = logged_in && (state_q == S_WAIT_SECOND)
                           && !second_strobe && timer_expired;
    assign score         = eval_score | timeout_score;
    assign hit_inc       = eval_score & is_match;
    assign miss_inc      = (eval_score & ~is_match) | timeout_score;
    assign last_round    = (round_bcd == LAST_ROUND_BCD);

    // Round FSM with first-player flag, timeout timer and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            first_p1_q    <= 1'b0;
            timer_q       <= '0;
            round_done_q  <= 1'b0;
            timeout_evt_q <= 1'b0;
            game_over_q   <= 1'b0;
        end else begin
            // Pulses line up with the counter update that scoring triggers.
            round_done_q  <= score;
            timeout_evt_q <= timeout_score;
            if (!logged_in) begin
                state_q     <= S_IDLE;
                first_p1_q  <= 1'b0;
                timer_q     <= '0;
                game_over_q <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        state_q <= S_WAIT_FIRST;
                    end
                    S_WAIT_FIRST: begin
                        if (load_p1 && load_p2) begin
                            state_q <= S_EVAL;
                        end else if (load_p1 || load_p2) begin
                            state_q    <= S_WAIT_SECOND;
                            first_p1_q <= load_p1;
                            timer_q    <= '0;
                        end
                    end
                    S_WAIT_SECOND: begin
                        // A qualifying strobe beats a simultaneous timeout;
                        // repeats by the first player neither score nor restart.
                        if (second_strobe) begin
                            state_q <= S_EVAL;
                        end else if (timer_expired) begin
                            state_q     <= last_round ? S_DONE : S_WAIT_FIRST;
                            game_over_q <= last_round;
                        end else begin
                            timer_q <= timer_q + TW'(1);
                        end
                    end
                    S_EVAL: begin
                        // One cycle here lets the load registers settle
                        // before is_match is trusted.
                        state_q     <= last_round ? S_DONE : S_WAIT_FIRST;
                        game_over_q <= last_round;
                    end
                    S_DONE: begin
                        game_over_q <= 1'b1;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    bcd_counter2 u_hits (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (hit_inc),
        .bcd (hits_bcd)
    );

    bcd_counter2 u_misses (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (miss_inc),
        .bcd (misses_bcd)
    );

    bcd_counter2 u_rounds (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (score),
        .bcd (round_bcd)
    );

    assign round_done  = round_done_q;
    assign timeout_evt = timeout_evt_q;
    assign game_over   = game_over_q;

endmodule
